sprite_actor: RTL and testbench

SPRITE_ACTOR -- requirements
Module: sprite_actor

---
 rtl/sprite_actor_if.sv | 47 ++++
 rtl/sprite_actor.sv | 226 ++++++++++++++++++++++
 tb/tb_sprite_actor.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_actor_if.sv
`default_nettype none
// sprite_actor_if: user commands, sheet-memory port and pixel output of one sprite actor.
interface sprite_actor_if #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
);
  localparam int ADDR_W = $clog2(8 * SPR_W * 3 * SPR_H);

  logic              init;
  logic              c_attack;
  logic              c_up;
  logic              c_down;
  logic              c_left;
  logic              c_right;
  logic              reg_action;
  logic              apply_action;
  logic              draw;
  logic [1:0]        collision;
  logic [5:0]        sprite_colour;
  logic [ADDR_W-1:0] sprite_addr;
  logic [X_W-1:0]    x_pos;
  logic [Y_W-1:0]    y_pos;
  logic [X_W-1:0]    x_draw;
  logic [Y_W-1:0]    y_draw;
  logic [2:0]        direction;
  logic [2:0]        facing;
  logic              attacking;
  logic              VGA_write;
  logic              draw_done;

  modport master (
    output init, c_attack, c_up, c_down, c_left, c_right, reg_action, apply_action,
           draw, collision, sprite_colour,
    input  sprite_addr, x_pos, y_pos, x_draw, y_draw, direction, facing, attacking,
           VGA_write, draw_done
  );

  modport slave (
    input  init, c_attack, c_up, c_down, c_left, c_right, reg_action, apply_action,
           draw, collision, sprite_colour,
    output sprite_addr, x_pos, y_pos, x_draw, y_draw, direction, facing, attacking,
           VGA_write, draw_done
  );
endinterface
`default_nettype wire

// File: rtl/sprite_actor.sv
`default_nettype none
// sprite_actor: moves/attacks an actor from user commands and rasters its sprite box
// out of an 8-cell-wide sheet memory, one pixel per cycle.
module sprite_actor #(
  parameter int         SPR_W      = 16,
  parameter int         SPR_H      = 16,
  parameter int         X_W        = 9,
  parameter int         Y_W        = 8,
  parameter int         STEP       = 1,
  parameter int         X_MIN      = 16,
  parameter int         X_MAX      = 303,
  parameter int         Y_MIN      = 16,
  parameter int         Y_MAX      = 223,
  parameter int         ATK_FRAMES = 8,
  parameter int         WALK_DIV   = 4,
  parameter logic [5:0] TRANSP     = 6'h3F,
  parameter int         INIT_X     = 16,
  parameter int         INIT_Y     = 96
) (
  input  wire logic     clock,
  input  wire logic     reset,
  sprite_actor_if.slave bus
);
  localparam int ADDR_W = $clog2(8 * SPR_W * 3 * SPR_H);
  localparam int PX_W   = $clog2(2 * SPR_W + 1);
  localparam int PY_W   = $clog2(2 * SPR_H + 1);
  localparam int AC_W   = $clog2(ATK_FRAMES + 1);
  localparam int WC_W   = $clog2(WALK_DIV + 1);

  localparam logic [2:0] ACT_NONE = 3'd0, ACT_ATTACK = 3'd1, ACT_UP = 3'd2,
                         ACT_DOWN = 3'd3, ACT_LEFT = 3'd4, ACT_RIGHT = 3'd5;
  localparam logic [2:0] F_UP = 3'd0, F_DOWN = 3'd1, F_LEFT = 3'd2, F_RIGHT = 3'd3;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic              clr;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [2:0]        facing_q, facing_d, direction_q, cmd_d;
  logic              attacking_q, walk_frame_q, step_ok;
  logic [AC_W-1:0]   atk_cnt_q;
  logic [WC_W-1:0]   walk_cnt_q;
  logic [PX_W-1:0]   px_q, w_q, w_d;
  logic [PY_W-1:0]   py_q, h_q, h_d;
  logic [X_W-1:0]    x0_q, x0_d, xd_q;
  logic [Y_W-1:0]    y0_q, y0_d, yd_q;
  logic [ADDR_W-1:0] col0_q, col0_d, row0_q, row0_d;
  logic              valid_q, last_px, is_move, unused_collision;

  assign clr              = reset | bus.init;
  assign unused_collision = bus.collision[1];
  assign is_move          = (direction_q == ACT_UP) || (direction_q == ACT_DOWN) ||
                            (direction_q == ACT_LEFT) || (direction_q == ACT_RIGHT);
  assign last_px          = (px_q == w_q - PX_W'(1)) && (py_q == h_q - PY_W'(1));

  always_comb begin
    cmd_d = ACT_NONE;
    if      (bus.c_attack) cmd_d = ACT_ATTACK;
    else if (bus.c_up)     cmd_d = ACT_UP;
    else if (bus.c_down)   cmd_d = ACT_DOWN;
    else if (bus.c_left)   cmd_d = ACT_LEFT;
    else if (bus.c_right)  cmd_d = ACT_RIGHT;
  end

  // A step that would leave the bounds lands on the bound and does not count as a walk step.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    facing_d = facing_q;
    step_ok  = 1'b0;
    case (direction_q)
      ACT_UP: begin
        facing_d = F_UP;
        if (int'(y_q) - STEP >= Y_MIN) begin y_d = y_q - Y_W'(STEP); step_ok = 1'b1; end
        else y_d = Y_W'(Y_MIN);
      end
      ACT_DOWN: begin
        facing_d = F_DOWN;
        if (int'(y_q) + STEP <= Y_MAX) begin y_d = y_q + Y_W'(STEP); step_ok = 1'b1; end
        else y_d = Y_W'(Y_MAX);
      end
      ACT_LEFT: begin
        facing_d = F_LEFT;
        if (int'(x_q) - STEP >= X_MIN) begin x_d = x_q - X_W'(STEP); step_ok = 1'b1; end
        else x_d = X_W'(X_MIN);
      end
      ACT_RIGHT: begin
        facing_d = F_RIGHT;
        if (int'(x_q) + STEP <= X_MAX) begin x_d = x_q + X_W'(STEP); step_ok = 1'b1; end
        else x_d = X_W'(X_MAX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      x_q          <= X_W'(INIT_X);
      y_q          <= Y_W'(INIT_Y);
      facing_q     <= F_DOWN;
      direction_q  <= ACT_NONE;
      attacking_q  <= 1'b0;
      atk_cnt_q    <= '0;
      walk_cnt_q   <= '0;
      walk_frame_q <= 1'b0;
    end else begin
      if (state_q == S_DONE && attacking_q) begin
        if (atk_cnt_q < AC_W'(2)) begin
          atk_cnt_q   <= '0;
          attacking_q <= 1'b0;
          direction_q <= ACT_NONE;
        end else begin
          atk_cnt_q <= atk_cnt_q - AC_W'(1);
        end
      end
      if (state_q == S_IDLE && !attacking_q) begin
        if (bus.reg_action) direction_q <= cmd_d;
        if (bus.apply_action && direction_q == ACT_ATTACK) begin
          attacking_q <= 1'b1;
          atk_cnt_q   <= AC_W'(ATK_FRAMES);
          direction_q <= ACT_ATTACK;
        end else if (bus.apply_action && is_move) begin
          facing_q <= facing_d;
          if (!bus.collision[0]) begin
            x_q <= x_d;
            y_q <= y_d;
            if (step_ok) begin
              if (walk_cnt_q == WC_W'(WALK_DIV - 1)) begin
                walk_cnt_q   <= '0;
                walk_frame_q <= ~walk_frame_q;
              end else begin
                walk_cnt_q <= walk_cnt_q + WC_W'(1);
              end
            end
          end
        end
      end
    end
  end

  // Box geometry and sheet cell origin, captured once when a pass starts.
  always_comb begin
    x0_d   = x_q;
    y0_d   = y_q;
    w_d    = PX_W'(SPR_W);
    h_d    = PY_W'(SPR_H);
    row0_d = '0;
    col0_d = ADDR_W'((2 * int'(facing_q) + int'(walk_frame_q)) * SPR_W);
    if (attacking_q) begin
      row0_d = ADDR_W'(SPR_H);
      col0_d = ADDR_W'(int'(facing_q) * 2 * SPR_W);
      case (facing_q)
        F_UP:    begin y0_d = y_q - Y_W'(SPR_H); h_d = PY_W'(2 * SPR_H); end
        F_DOWN:  h_d = PY_W'(2 * SPR_H);
        F_LEFT:  begin x0_d = x_q - X_W'(SPR_W); w_d = PX_W'(2 * SPR_W); end
        default: w_d = PX_W'(2 * SPR_W);
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.draw) state_d = S_SCAN;
      S_SCAN:  if (!bus.draw) state_d = S_IDLE; else if (last_px) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_WAIT;
      S_WAIT:  if (!bus.draw) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= S_IDLE;
      px_q    <= '0;
      py_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col0_q  <= '0;
      row0_q  <= '0;
      xd_q    <= '0;
      yd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == S_SCAN) && bus.draw;
      if (state_q == S_IDLE && bus.draw) begin
        px_q   <= '0;
        py_q   <= '0;
        x0_q   <= x0_d;
        y0_q   <= y0_d;
        w_q    <= w_d;
        h_q    <= h_d;
        col0_q <= col0_d;
        row0_q <= row0_d;
      end else if (state_q == S_SCAN) begin
        xd_q <= x0_q + X_W'(px_q);
        yd_q <= y0_q + Y_W'(py_q);
        if (px_q == w_q - PX_W'(1)) begin
          px_q <= '0;
          py_q <= py_q + PY_W'(1);
        end else begin
          px_q <= px_q + PX_W'(1);
        end
      end
    end
  end

  assign bus.sprite_addr = (state_q == S_SCAN)
                         ? (row0_q + ADDR_W'(py_q)) * ADDR_W'(8 * SPR_W) + col0_q + ADDR_W'(px_q)
                         : '0;
  assign bus.x_pos       = x_q;
  assign bus.y_pos       = y_q;
  assign bus.x_draw      = xd_q;
  assign bus.y_draw      = yd_q;
  assign bus.direction   = direction_q;
  assign bus.facing      = facing_q;
  assign bus.attacking   = attacking_q;
  assign bus.VGA_write   = valid_q && (bus.sprite_colour != TRANSP);
  assign bus.draw_done   = (state_q == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_sprite_actor.sv
`default_nettype none
// tb_sprite_actor: directed bench for sprite_actor with a behavioural sheet memory.
module tb_sprite_actor;
  logic clock = 1'b0;
  logic reset;
  logic transp_all;
  int   checks = 0;
  int   errors = 0;
  int   cyc, wr, a0, fx, fy, minx, maxx, extra, dones;

  always #5 clock = ~clock;

  sprite_actor_if bus ();
  sprite_actor dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always @(posedge clock)
    bus.sprite_colour <= transp_all ? 6'h3F : {1'b0, bus.sprite_addr[4:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cmd bits: {attack, up, down, left, right}
  task automatic latch(input logic [4:0] cmd);
    {bus.c_attack, bus.c_up, bus.c_down, bus.c_left, bus.c_right} = cmd;
    bus.reg_action = 1'b1;
    @(negedge clock);
    bus.reg_action = 1'b0;
    {bus.c_attack, bus.c_up, bus.c_down, bus.c_left, bus.c_right} = 5'b0;
  endtask

  task automatic apply(input int n);
    bus.apply_action = 1'b1;
    repeat (n) @(negedge clock);
    bus.apply_action = 1'b0;
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    @(negedge clock);
    bus.init = 1'b0;
  endtask

  task automatic do_draw(output int n, output int w, output int addr0, output int x_first,
                         output int y_first, output int xmin, output int xmax, output int late);
    int  prev_addr;
    bit  seen;
    n = 0; w = 0; addr0 = -1; x_first = -1; y_first = -1; xmin = 9999; xmax = -1;
    prev_addr = 0; seen = 1'b0;
    bus.draw = 1'b1;
    do begin
      @(negedge clock);
      n++;
      if (bus.VGA_write === 1'b1) begin
        if (!seen) begin
          addr0 = prev_addr; x_first = int'(bus.x_draw); y_first = int'(bus.y_draw); seen = 1'b1;
        end
        w++;
        if (int'(bus.x_draw) < xmin) xmin = int'(bus.x_draw);
        if (int'(bus.x_draw) > xmax) xmax = int'(bus.x_draw);
      end
      prev_addr = int'(bus.sprite_addr);
    end while (bus.draw_done !== 1'b1 && n < 2000);
    bus.draw = 1'b0;
    @(negedge clock);
    late = int'(bus.draw_done);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; transp_all = 1'b0;
    bus.init = 1'b0; bus.reg_action = 1'b0; bus.apply_action = 1'b0; bus.draw = 1'b0;
    bus.collision = 2'b00;
    {bus.c_attack, bus.c_up, bus.c_down, bus.c_left, bus.c_right} = 5'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_x_pos", bus.x_pos, 16);
    chk("rst_y_pos", bus.y_pos, 96);
    chk("rst_facing", bus.facing, 1);
    chk("rst_direction", bus.direction, 0);
    chk("rst_attacking", bus.attacking, 0);
    chk("rst_sprite_addr", bus.sprite_addr, 0);
    chk("rst_x_draw", bus.x_draw, 0);
    chk("rst_y_draw", bus.y_draw, 0);
    chk("rst_vga_write", bus.VGA_write, 0);
    chk("rst_draw_done", bus.draw_done, 0);

    do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("def_cycles", cyc, 258);
    chk("def_writes", wr, 256);
    chk("def_addr0", a0, 32);
    chk("def_x_first", fx, 16);
    chk("def_y_first", fy, 96);
    chk("def_x_max", maxx, 31);
    chk("def_done_single", extra, 0);

    latch(5'b00100);
    chk("walk_direction", bus.direction, 3);
    apply(3);
    chk("walk_y3", bus.y_pos, 99);
    do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("walk3_addr0", a0, 32);
    apply(1);
    chk("walk_y4", bus.y_pos, 100);
    do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("walk4_addr0", a0, 48);
    chk("walk4_y_first", fy, 100);

    latch(5'b01000);
    chk("blk_direction", bus.direction, 2);
    bus.collision = 2'b01;
    apply(1);
    bus.collision = 2'b00;
    chk("blk_y_pos", bus.y_pos, 100);
    chk("blk_facing", bus.facing, 0);

    bus.draw = 1'b1;
    repeat (10) @(negedge clock);
    bus.draw = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.draw_done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);

    bus.draw = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    bus.draw = 1'b0;
    @(negedge clock);
    chk("midscan_rst_vga", bus.VGA_write, 0);
    chk("midscan_rst_y", bus.y_pos, 96);
    reset = 1'b0;

    latch(5'b00001);
    apply(2);
    chk("pre_init_x", bus.x_pos, 18);
    pulse_init();
    chk("init_x_pos", bus.x_pos, 16);
    chk("init_facing", bus.facing, 1);
    chk("init_direction", bus.direction, 0);

    latch(5'b00001);
    apply(300);
    chk("clamp_x_pos", bus.x_pos, 303);
    chk("clamp_facing", bus.facing, 3);
    do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("clamp_addr0", a0, 112);
    chk("clamp_x_first", fx, 303);

    pulse_init();
    latch(5'b00001);
    apply(84);
    chk("atk_x_start", bus.x_pos, 100);
    latch(5'b00010);
    bus.collision = 2'b01;
    apply(1);
    bus.collision = 2'b00;
    chk("atk_face_left", bus.facing, 2);
    chk("atk_x_blocked", bus.x_pos, 100);
    latch(5'b10000);
    chk("atk_direction", bus.direction, 1);
    apply(1);
    chk("atk_attacking", bus.attacking, 1);
    chk("atk_x_pos", bus.x_pos, 100);
    do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("atk_cycles", cyc, 514);
    chk("atk_writes", wr, 512);
    chk("atk_addr0", a0, 2112);
    chk("atk_x_min", minx, 84);
    chk("atk_x_max", maxx, 115);
    chk("atk_y_first", fy, 96);
    latch(5'b01000);
    chk("atk_cmd_ignored", bus.direction, 1);
    repeat (6) do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("atk_after7", bus.attacking, 1);
    do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("atk_after8", bus.attacking, 0);
    chk("atk_dir_cleared", bus.direction, 0);

    transp_all = 1'b1;
    do_draw(cyc, wr, a0, fx, fy, minx, maxx, extra);
    chk("transp_writes", wr, 0);
    chk("transp_cycles", cyc, 258);
    chk("transp_done_single", extra, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
